// File: rtl/tm1637_pkg.sv
// Shared command-field constants, FSM state encoding and decode helper
// for the TM1637-style display bus responder.
package tm1637_pkg;

  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_DATA = 2'b01;
  localparam logic [1:0] CMD_DISP = 2'b10;
  localparam logic [1:0] CMD_ADDR = 2'b11;

  localparam int BIT_READ    = 1;
  localparam int BIT_FIXED   = 2;
  localparam int BIT_DISP_ON = 3;

  localparam logic [2:0] PTR_MAX = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_RDATA,
    ST_ACK,
    ST_RACK
  } state_t;

  function automatic logic [1:0] cmd_kind(input logic [7:0] b);
    return b[7:6];
  endfunction

endpackage

// File: rtl/tm1637_resp_if.sv
// Two-wire display bus as seen at the pads: bus clock/data levels in,
// open-drain data pull-down out.
interface tm1637_resp_if;
  logic scl_in;
  logic sda_in;
  logic sda_en;
  logic sda_out;

  modport master (output scl_in, output sda_in, input sda_en, input sda_out);
  modport slave  (input scl_in, input sda_in, output sda_en, output sda_out);
endinterface

// File: rtl/tm1637_bus_sync.sv
// Synchronizes the asynchronous bus pads and emits one-cycle START, STOP,
// SCL-rise and SCL-fall pulses from the synchronized levels.
module tm1637_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_start,
  output logic o_stop,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  logic                   w_scl;
  logic                   w_sda;

  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];

  // Filled with 1 so a freshly reset chain looks like an idle bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  assign o_sda   = w_sda;
  assign o_start = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign o_stop  = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign o_rise  = w_scl & ~r_scl_d;
  assign o_fall  = ~w_scl & r_scl_d;

endmodule

// File: rtl/tm1637_resp.sv
// TM1637-compatible bus responder: decodes data/address/display commands,
// stores display bytes, ACKs received bytes and shifts out the key-scan byte.
module tm1637_resp
  import tm1637_pkg::*;
#(
  parameter int NUM_GRIDS   = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  tm1637_resp_if.slave           bus,
  input  logic [7:0]             key_in,
  output logic [8*NUM_GRIDS-1:0] seg_data,
  output logic                   disp_on,
  output logic [2:0]             brightness,
  output logic                   frame_done
);

  logic w_sda, w_start, w_stop, w_rise, w_fall;

  tm1637_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_scl   (bus.scl_in),
    .i_sda   (bus.sda_in),
    .o_sda   (w_sda),
    .o_start (w_start),
    .o_stop  (w_stop),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  state_t     r_state, w_state_nxt;
  state_t     r_ret, w_ret_nxt;
  logic [2:0] r_rbit, w_rbit_nxt;
  logic       r_sda_en, w_sda_en_nxt;
  logic [3:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic       r_lock;
  logic       r_fixed;
  logic [2:0] r_ptr;
  logic [7:0] r_key;
  logic       r_disp_on;
  logic [2:0] r_bright;
  logic       r_wrote;
  logic       r_frame_done;
  logic [7:0] r_seg [NUM_GRIDS];

  logic w_rx_active, w_byte_end, w_ptr_ok;
  logic w_set_mode, w_set_addr, w_set_disp, w_wr, w_cap_key;

  // A locked CMD state has already answered its command; later bytes are ignored.
  assign w_rx_active = (r_state == ST_WDATA) || (r_state == ST_CMD && !r_lock);
  assign w_byte_end  = w_rx_active && w_fall && (r_bit_cnt == 4'd8);
  assign w_ptr_ok    = (32'(r_ptr) < NUM_GRIDS);

  always_comb begin
    w_state_nxt = r_state;
    w_ret_nxt   = r_ret;
    w_rbit_nxt  = r_rbit;
    w_set_mode  = 1'b0;
    w_set_addr  = 1'b0;
    w_set_disp  = 1'b0;
    w_wr        = 1'b0;
    w_cap_key   = 1'b0;
    if (w_stop) begin
      w_state_nxt = ST_IDLE;
    end else if (w_start) begin
      w_state_nxt = ST_CMD;
    end else begin
      case (r_state)
        ST_CMD: begin
          if (w_byte_end) begin
            case (cmd_kind(r_shift))
              CMD_DATA: begin
                w_set_mode  = 1'b1;
                w_cap_key   = r_shift[BIT_READ];
                w_ret_nxt   = r_shift[BIT_READ] ? ST_RDATA : ST_CMD;
                w_state_nxt = ST_ACK;
              end
              CMD_ADDR: begin
                w_set_addr  = 1'b1;
                w_ret_nxt   = ST_WDATA;
                w_state_nxt = ST_ACK;
              end
              CMD_DISP: begin
                w_set_disp  = 1'b1;
                w_ret_nxt   = ST_CMD;
                w_state_nxt = ST_ACK;
              end
              CMD_NONE: w_state_nxt = ST_IDLE;
              default:  w_state_nxt = ST_IDLE;
            endcase
          end
        end
        ST_WDATA: begin
          if (w_byte_end) begin
            w_wr        = 1'b1;
            w_ret_nxt   = ST_WDATA;
            w_state_nxt = ST_ACK;
          end
        end
        ST_ACK: begin
          if (w_fall) begin
            w_state_nxt = r_ret;
            w_rbit_nxt  = 3'd0;
          end
        end
        ST_RDATA: begin
          if (w_fall) begin
            if (r_rbit == 3'd7) w_state_nxt = ST_RACK;
            else                w_rbit_nxt  = r_rbit + 3'd1;
          end
        end
        ST_RACK: begin
          if (w_fall) w_state_nxt = ST_CMD;
        end
        default: ;
      endcase
    end

    case (w_state_nxt)
      ST_ACK:   w_sda_en_nxt = 1'b1;
      ST_RDATA: w_sda_en_nxt = ~r_key[w_rbit_nxt];
      default:  w_sda_en_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_ret    <= ST_CMD;
      r_rbit   <= 3'd0;
      r_sda_en <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ret    <= w_ret_nxt;
      r_rbit   <= w_rbit_nxt;
      r_sda_en <= w_sda_en_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt    <= 4'd0;
      r_shift      <= 8'd0;
      r_lock       <= 1'b0;
      r_fixed      <= 1'b0;
      r_ptr        <= 3'd0;
      r_key        <= 8'd0;
      r_disp_on    <= 1'b0;
      r_bright     <= 3'd0;
      r_wrote      <= 1'b0;
      r_frame_done <= 1'b0;
      for (int g = 0; g < NUM_GRIDS; g++) r_seg[g] <= 8'd0;
    end else begin
      if (w_start || w_stop || w_byte_end) begin
        r_bit_cnt <= 4'd0;
      end else if (w_rx_active && w_rise && r_bit_cnt != 4'd8) begin
        r_shift   <= {w_sda, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end

      if (w_start)                                          r_lock <= 1'b0;
      else if (w_state_nxt == ST_CMD && r_state != ST_CMD) r_lock <= 1'b1;

      if (w_set_mode) r_fixed <= r_shift[BIT_FIXED];
      if (w_set_disp) begin
        r_disp_on <= r_shift[BIT_DISP_ON];
        r_bright  <= r_shift[2:0];
      end
      if (w_cap_key) r_key <= key_in;

      // Out-of-range pointers still advance, saturating rather than wrapping.
      if (w_set_addr)                             r_ptr <= r_shift[2:0];
      else if (w_wr && !r_fixed && r_ptr != PTR_MAX) r_ptr <= r_ptr + 3'd1;

      if (w_wr) begin
        for (int g = 0; g < NUM_GRIDS; g++) begin
          if (r_ptr == 3'(g)) r_seg[g] <= r_shift;
        end
      end

      if (w_start || w_stop)   r_wrote <= 1'b0;
      else if (w_wr && w_ptr_ok) r_wrote <= 1'b1;

      r_frame_done <= w_stop && r_wrote;
    end
  end

  always_comb begin
    seg_data = '0;
    for (int g = 0; g < NUM_GRIDS; g++) seg_data[g*8 +: 8] = r_seg[g];
  end

  assign bus.sda_en  = r_sda_en;
  assign bus.sda_out = 1'b0;
  assign disp_on     = r_disp_on;
  assign brightness  = r_bright;
  assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_tm1637_resp.sv
// Directed bench for tm1637_resp: drives the two-wire bus as an open-drain
// master and checks the outputs against a transaction-level model.
module tb_tm1637_resp;

  localparam int NG = 6;
  localparam int Q  = 6;
  localparam int H  = 12;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [7:0]      key_in = 8'h00;
  logic [8*NG-1:0] seg_data;
  logic            disp_on;
  logic [2:0]      brightness;
  logic            frame_done;
  logic            m_scl = 1'b1;
  logic            m_sda = 1'b1;

  tm1637_resp_if bus();
  assign bus.scl_in = m_scl;
  assign bus.sda_in = m_sda & ~bus.sda_en;

  tm1637_resp #(.NUM_GRIDS(NG), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .key_in     (key_in),
    .seg_data   (seg_data),
    .disp_on    (disp_on),
    .brightness (brightness),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  logic       chk_en   = 1'b0;
  int         frame_cnt = 0;

  logic [7:0] m_seg [NG];
  logic       m_disp  = 1'b0;
  logic [2:0] m_bri   = 3'd0;
  logic       m_fixed = 1'b0;
  int         m_ptr   = 0;
  int         m_frames = 0;
  logic [7:0] txq [$];

  function automatic logic [8*NG-1:0] model_seg();
    logic [8*NG-1:0] r;
    for (int g = 0; g < NG; g++) r[g*8 +: 8] = m_seg[g];
    return r;
  endfunction

  task automatic model_reset();
    for (int g = 0; g < NG; g++) m_seg[g] = 8'h00;
    m_disp  = 1'b0;
    m_bri   = 3'd0;
    m_fixed = 1'b0;
    m_ptr   = 0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (frame_done === 1'b1) frame_cnt++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (seg_data !== model_seg() || disp_on !== m_disp || brightness !== m_bri ||
          bus.sda_en !== 1'b0 || bus.sda_out !== 1'b0) begin
        failures++;
        $display("FAIL idle_outputs seg=%h/%h disp=%b/%b bri=%0d/%0d sda_en=%b sda_out=%b",
                 seg_data, model_seg(), disp_on, m_disp, brightness, m_bri, bus.sda_en, bus.sda_out);
      end
    end
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; m_scl = 1'b1; wclk(Q);
    m_sda = 1'b0; wclk(Q);
    m_scl = 1'b0; wclk(Q);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wclk(Q);
    m_scl = 1'b1; wclk(Q);
    m_sda = 1'b1; wclk(Q);
  endtask

  // n == 8 adds the ninth (acknowledge) clock with SDA released by the master.
  task automatic send_bits(input logic [7:0] b, input int n, output logic ack_low);
    ack_low = 1'b0;
    for (int i = 0; i < n; i++) begin
      m_sda = b[i]; wclk(Q);
      m_scl = 1'b1; wclk(H);
      chk("bit_nodrive", 64'(bus.sda_en), 64'd0);
      m_scl = 1'b0; wclk(Q);
    end
    if (n == 8) begin
      m_sda = 1'b1; wclk(Q);
      m_scl = 1'b1; wclk(H);
      ack_low = (bus.sda_in === 1'b0);
      m_scl = 1'b0; wclk(Q);
    end
  endtask

  task automatic wr_txn(input int last_bits);
    logic [1:0] kind;
    logic       ack;
    logic       exp_ack;
    logic       wrote;
    int         nb;
    chk_en = 1'b0;
    bus_start();
    kind  = txq[0][7:6];
    wrote = 1'b0;
    for (int i = 0; i < txq.size(); i++) begin
      nb = (i == txq.size() - 1) ? last_bits : 8;
      send_bits(txq[i], nb, ack);
      if (nb == 8) begin
        exp_ack = 1'b0;
        if (i == 0) begin
          exp_ack = (kind != 2'b00);
          case (kind)
            2'b01: m_fixed = txq[0][2];
            2'b10: begin m_disp = txq[0][3]; m_bri = txq[0][2:0]; end
            2'b11: m_ptr = int'(txq[0][2:0]);
            default: ;
          endcase
        end else if (kind == 2'b11) begin
          exp_ack = 1'b1;
          if (m_ptr < NG) begin
            m_seg[m_ptr] = txq[i];
            wrote = 1'b1;
          end
          if (!m_fixed && m_ptr < 7) m_ptr++;
        end
        chk($sformatf("ack_byte%0d_%h", i, txq[i]), 64'(ack), 64'(exp_ack));
      end
    end
    bus_stop();
    if (wrote) m_frames++;
    wclk(4);
    chk("frame_count", 64'(frame_cnt), 64'(m_frames));
    chk_en = 1'b1;
  endtask

  task automatic rd_txn(input logic [7:0] cmd, input logic [7:0] exp_byte);
    logic       ack;
    logic [7:0] obs;
    chk_en = 1'b0;
    bus_start();
    send_bits(cmd, 8, ack);
    chk("read_cmd_ack", 64'(ack), 64'd1);
    m_fixed = cmd[2];
    for (int i = 0; i < 8; i++) begin
      m_sda = 1'b1; wclk(Q);
      m_scl = 1'b1; wclk(H);
      obs[i] = bus.sda_in;
      chk($sformatf("read_bit%0d", i), 64'(obs[i]), 64'(key_in[i]));
      m_scl = 1'b0; wclk(Q);
    end
    chk("read_byte", 64'(obs), 64'(exp_byte));
    m_sda = 1'b1; wclk(Q);
    m_scl = 1'b1; wclk(H);
    chk("read_ack_release", 64'(bus.sda_in), 64'd1);
    m_scl = 1'b0; wclk(Q);
    bus_stop();
    wclk(4);
    chk("frame_count", 64'(frame_cnt), 64'(m_frames));
    chk_en = 1'b1;
  endtask

  initial begin
    logic ack;
    model_reset();
    rst = 1'b1;
    wclk(5);
    chk("rst_seg", 64'(seg_data), 64'd0);
    chk("rst_disp", 64'(disp_on), 64'd0);
    chk("rst_bri", 64'(brightness), 64'd0);
    chk("rst_sda_en", 64'(bus.sda_en), 64'd0);
    chk("rst_sda_out", 64'(bus.sda_out), 64'd0);
    chk("rst_frame", 64'(frame_done), 64'd0);
    rst = 1'b0;
    wclk(5);
    chk_en = 1'b1;

    txq = {8'h40}; wr_txn(8);
    txq = {8'hC0, 8'h7F, 8'h79, 8'h79, 8'h71}; wr_txn(8);
    chk("seg_auto_inc", 64'(seg_data), 64'h00007179797F);
    chk("frames_after_auto", 64'(frame_cnt), 64'd1);

    txq = {8'h44}; wr_txn(8);
    txq = {8'hC2, 8'hAA, 8'h55}; wr_txn(8);
    chk("seg_fixed", 64'(seg_data), 64'h00007155797F);
    chk("frames_after_fixed", 64'(frame_cnt), 64'd2);

    txq = {8'h8F}; wr_txn(8);
    chk("disp_on_lit", 64'(disp_on), 64'd1);
    chk("bri_lit", 64'(brightness), 64'd7);
    chk("seg_after_disp", 64'(seg_data), 64'h00007155797F);
    chk("frames_after_disp", 64'(frame_cnt), 64'd2);

    txq = {8'h40, 8'h99}; wr_txn(8);
    txq = {8'h05}; wr_txn(8);
    txq = {8'hC0, 8'hEE}; wr_txn(3);
    chk("seg_after_partial", 64'(seg_data), 64'h00007155797F);

    key_in = 8'hA5;
    rd_txn(8'h42, 8'hA5);

    txq = {8'h40}; wr_txn(8);
    txq = {8'hC5, 8'h11, 8'h22, 8'h33, 8'h44}; wr_txn(8);
    chk("seg_overflow", 64'(seg_data), 64'h11007155797F);
    chk("frames_after_overflow", 64'(frame_cnt), 64'd3);

    chk_en = 1'b0;
    bus_start();
    send_bits(8'hC0, 4, ack);
    rst = 1'b1;
    wclk(3);
    model_reset();
    chk("midrst_seg", 64'(seg_data), 64'd0);
    chk("midrst_disp", 64'(disp_on), 64'd0);
    chk("midrst_bri", 64'(brightness), 64'd0);
    chk("midrst_sda_en", 64'(bus.sda_en), 64'd0);
    chk("midrst_frame", 64'(frame_done), 64'd0);
    m_scl = 1'b1; wclk(2);
    m_sda = 1'b1; wclk(3);
    rst = 1'b0;
    wclk(5);
    chk_en = 1'b1;

    txq = {8'h40}; wr_txn(8);
    txq = {8'hC1, 8'h3C}; wr_txn(8);
    chk("seg_after_reset", 64'(seg_data), 64'h000000003C00);

    wclk(10);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
